// File: rtl/imem_uart_loader.sv
// UART (8N1) boot loader: receives a framed image and writes it word by word into
// the instruction memory, holding the core in reset until the checksum matches.
//
//   state | meaning
//   SYNC  | waiting for the 0xA5 sync byte
//   LEN0  | expecting the low byte of the word count
//   LEN1  | expecting the high byte of the word count
//   DATA  | assembling data words and writing them to memory
//   CSUM  | expecting the XOR checksum of all data bytes
//   DONE  | image loaded, core released; a new sync byte restarts a load
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [3:0]  mem_we,
  output logic [12:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        core_rst_n,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]   MAX_LEN     = 16'(MAX_WORDS);
  localparam logic [7:0]    SYNC_BYTE   = 8'hA5;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] SYNC = 3'd0;
  localparam logic [2:0] LEN0 = 3'd1;
  localparam logic [2:0] LEN1 = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  // receiver state
  logic          rx_meta_q,  rx_meta_d;
  logic          rx_sync_q,  rx_sync_d;
  logic          rx_prev_q,  rx_prev_d;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]    rx_bit_q,   rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q,  rx_ferr_d;

  // loader state
  logic [2:0]    state_q,      state_d;
  logic [15:0]   len_q,        len_d;
  logic [10:0]   word_idx_q,   word_idx_d;
  logic [1:0]    byte_idx_q,   byte_idx_d;
  logic [31:0]   word_q,       word_d;
  logic [7:0]    csum_q,       csum_d;
  logic          busy_q,       busy_d;
  logic          err_q,        err_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic [3:0]    mem_we_q,     mem_we_d;
  logic [12:0]   mem_addr_q,   mem_addr_d;
  logic [31:0]   mem_din_q,    mem_din_d;

  logic [15:0]   len_full;
  logic [31:0]   word_next;

  // Synchronizer and edge history reset low, so a start edge is only seen after
  // the line has been observed idle-high following reset.
  always_comb begin
    rx_meta_d  = uart_rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_RELOAD;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_RELOAD;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) rx_valid_d = 1'b1;
          else           rx_ferr_d  = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
    endcase
  end

  assign len_full  = {rx_shift_q, len_q[7:0]};
  assign word_next = {rx_shift_q, word_q[31:8]};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    busy_d       = busy_q;
    err_d        = err_q;
    core_rst_n_d = core_rst_n_q;
    mem_we_d     = 4'h0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    if (rx_ferr_q) begin
      state_d = SYNC;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (rx_valid_q) begin
      case (state_q)
        SYNC, DONE: begin
          if (rx_shift_q == SYNC_BYTE) begin
            state_d      = LEN0;
            busy_d       = 1'b1;
            err_d        = 1'b0;
            core_rst_n_d = 1'b0;
            word_idx_d   = 11'd0;
            byte_idx_d   = 2'd0;
            csum_d       = 8'h00;
          end
        end
        LEN0: begin
          len_d   = {8'h00, rx_shift_q};
          state_d = LEN1;
        end
        LEN1: begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = CSUM;
          end else if (len_full > MAX_LEN) begin
            state_d = SYNC;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          csum_d     = csum_q ^ rx_shift_q;
          word_d     = word_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_we_d   = 4'hF;
            mem_addr_d = {word_idx_q, 2'b00};
            mem_din_d  = word_next;
            // The index stops at the last word instead of incrementing past it.
            if ({5'd0, word_idx_q} == len_q - 16'd1) state_d = CSUM;
            else                                      word_idx_d = word_idx_q + 11'd1;
          end
        end
        CSUM: begin
          busy_d = 1'b0;
          if (rx_shift_q == csum_q) begin
            state_d      = DONE;
            core_rst_n_d = 1'b1;
          end else begin
            state_d = SYNC;
            err_d   = 1'b1;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b0;
      rx_sync_q    <= 1'b0;
      rx_prev_q    <= 1'b0;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_ferr_q    <= 1'b0;
      state_q      <= SYNC;
      len_q        <= 16'd0;
      word_idx_q   <= 11'd0;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      csum_q       <= 8'h00;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      mem_we_q     <= 4'h0;
      mem_addr_q   <= 13'd0;
      mem_din_q    <= 32'd0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_valid_q   <= rx_valid_d;
      rx_ferr_q    <= rx_ferr_d;
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
